keypad_matrix_scanner: RTL
==========================

// Module: keypad_matrix_scanner
// PURPOSE
//  Parametrised successor to the 4x4 game keypad scanner. Scans an ROWS x COLS matrix one row per slot,
//  debounces every key independently and publishes a full pressed-key bitmap, so that simultaneous
//  keys (both players moving at once) are all seen. Also emits one-cycle press/release events.
//  Sits between the keypad pins and the paddle/game-control logic, clocked by the slow scan clock.
// PARAMETERS
//  ROWS      4  number of driven row lines (>=2)
//  COLS      4  number of sensed column lines (>=1)
//  SETTLE    1  idle cycles after a row change before columns are sampled (0..7)
//  DEBOUNCE  3  consecutive identical samples needed to change a key's stable state (1..15)
// PORTS
//  clk        in   1          scan clock (rising edge)
//  rst        in   1          asynchronous, active-low reset
//  kp_col     in   COLS       column sense, active-low (0 = key in driven row closed)
//  kp_row     out  ROWS       row drive, one-cold (exactly one bit 0)
//  key_state  out  ROWS*COLS  debounced bitmap; bit r*COLS+c = key(row r, col c) held
//  key_press  out  ROWS*COLS  1-cycle pulse per key whose stable state went 0->1
//  key_rel    out  ROWS*COLS  1-cycle pulse per key whose stable state went 1->0
//  key_valid  out  1          1-cycle pulse: at least one key_press bit set this frame
//  key_code   out  clog2(ROWS*COLS)  index of lowest-numbered newly pressed key; held until next valid
//  frame_done out  1          1-cycle pulse after the last row of a frame is sampled
// BEHAVIOUR
//  - Reset: kp_row = ~1 (row 0 driven); key_state, key_press, key_rel, key_valid, key_code, frame_done,
//    all debounce counters and the FSM clear to 0 / SETTLE state, row index 0.
//  - FSM per row: SETTLE (SETTLE cycles, skipped if SETTLE=0) -> SAMPLE (1 cycle) -> advance row.
//    Row slot = SETTLE+1 cycles; frame = ROWS*(SETTLE+1) cycles (8 at defaults).
//  - SAMPLE: raw(r,c) = ~kp_col[c] for current row r. If raw == key_state bit, counter <= 0;
//    else counter++; when counter reaches DEBOUNCE-1 on a mismatching sample, stable bit flips, counter <= 0.
//    Net: a change is accepted on the DEBOUNCE-th consecutive differing sample of that key.
//  - Row advance: row index wraps ROWS-1 -> 0; kp_row = ~(1<<idx) updates in the same edge as the index.
//  - Events: key_press/key_rel asserted the cycle after the flipping SAMPLE, for exactly 1 cycle.
//    Flips accumulate over a frame; key_valid/key_code computed on the last row's SAMPLE and presented
//    together with frame_done. key_code = lowest set index of that frame's accumulated press set.
//  - Simultaneous press and release of different keys in one frame: both reported; no priority loss.
//  - A bounce shorter than DEBOUNCE samples never changes key_state nor raises events.
//  - Reset asserted mid-frame: everything returns to reset values immediately; no event is emitted.
//  - kp_col sampled only in SAMPLE; values in SETTLE are ignored. kp_col assumed synchronised externally.
// CONFIGURATION
//  KP_GHOST_REJECT_EN defined: at frame end, if the accumulated raw bitmap contains any rectangle
//   (two rows sharing two closed columns), the frame's flips are discarded: key_state, counters and
//   events stay as before the frame; key_valid not raised. Undefined: no ghost check, flips apply as
//   sampled. Without the macro events fire at row granularity; with it all state commits at frame end.
// STRUCTURE
//  - Package keypad_pkg: scan FSM state enum (ST_SETTLE, ST_SAMPLE), ROW_IDLE constant, function
//    kp_index(row,col), helper for lowest-set-bit encode.
//  - One sub-module: keypad_key_debounce (one counter + stable bit + edge flags), instantiated
//    ROWS*COLS times via generate; top holds FSM, row driver, event aggregation, ghost check.
// TESTING (defaults: ROWS=4 COLS=4 SETTLE=1 DEBOUNCE=3)
//  1 Reset release, no keys: kp_row cycles 1110,1101,1011,0111 every 2 clk; frame_done every 8 clk; key_state=0.
//  2 Hold key(3,1) (kp_col=1101 when kp_row=0111) 3 frames -> key_state[13]=1, one key_press[13] pulse,
//    key_valid with key_code=13; releasing 3 frames -> key_rel[13] pulse, key_state[13]=0.
//  3 Key(0,0) closed 2 frames then open -> no key_state change, no key_press/key_valid.
//  4 Keys 4 and 8 pressed in the same frame -> key_state[4],[8]=1 same frame, key_code=4.
//  5 Assert rst in mid-frame while key 5 is stable -> key_state=0, kp_row=1110 immediately, no key_rel.
//  6 With KP_GHOST_REJECT_EN: keys 0,1,4 held -> key_state stays 0, key_valid never; release 4 -> 0,1 accepted.

Source files
------------

// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_pkg: scan FSM states, idle row level and index helpers shared by the keypad scanner
package keypad_pkg;
  typedef enum logic {ST_SETTLE, ST_SAMPLE} state_t;
  localparam logic ROW_IDLE = 1'b1;
  function automatic int kp_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction
  function automatic int lsb_index(input logic [63:0] v);
    lsb_index = 0;
    for (int i = 63; i >= 0; i--) if (v[i]) lsb_index = i;
  endfunction
endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if: keypad pins plus the debounced bitmap and event outputs
interface keypad_matrix_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int N = ROWS * COLS;
  localparam int CW = $clog2(N);
  logic [COLS-1:0] kp_col;
  logic [ROWS-1:0] kp_row;
  logic [N-1:0] key_state;
  logic [N-1:0] key_press;
  logic [N-1:0] key_rel;
  logic key_valid;
  logic [CW-1:0] key_code;
  logic frame_done;
  modport master(input kp_col, output kp_row, key_state, key_press, key_rel, key_valid, key_code, frame_done);
  modport slave(output kp_col, input kp_row, key_state, key_press, key_rel, key_valid, key_code, frame_done);
endinterface

// File: rtl/keypad_matrix_scanner_key_debounce.sv
// keypad_key_debounce: one key's run counter, stable state and registered press/release pulses
module keypad_key_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic stable,
  output logic press,
  output logic rel,
  output logic press_now
);
  logic [3:0] cnt;
  logic diff, flip;
  assign diff = en && raw != stable;
  assign flip = diff && cnt == 4'(DEBOUNCE - 1);
  assign press_now = flip && !stable;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      stable <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      press <= press_now;
      rel <= flip && stable;
      stable <= stable ^ flip;
      if (en) cnt <= diff && !flip ? cnt + 4'd1 : '0;
    end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row scanner with per-key debounce and events; KP_GHOST_REJECT_EN commits at frame end and drops ghosted frames
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SETTLE = 1,
  parameter int DEBOUNCE = 3
) (
  input logic clk,
  input logic rst,
  keypad_matrix_scanner_if.master kp
);
  localparam int N = ROWS * COLS;
  localparam int CW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam state_t ST_INIT = SETTLE == 0 ? ST_SAMPLE : ST_SETTLE;
  state_t state, state_nx;
  logic [2:0] scnt, scnt_nx;
  logic [RW-1:0] idx, idx_nx;
  logic sample, frame_end, key_valid, frame_done;
  logic [CW-1:0] key_code;
  logic [ROWS-1:0] row_drv;
  logic [N-1:0] row_en, row_raw, en, raw, stable, press, rel, press_now, acc, acc_full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_INIT;
      scnt <= '0;
      idx <= '0;
    end else begin
      state <= state_nx;
      scnt <= scnt_nx;
      idx <= idx_nx;
    end
  always_comb begin
    sample = state == ST_SAMPLE;
    frame_end = sample && idx == RW'(ROWS - 1);
    state_nx = sample ? ST_INIT : scnt == 3'(SETTLE - 1) ? ST_SAMPLE : ST_SETTLE;
    scnt_nx = sample || scnt == 3'(SETTLE - 1) ? '0 : scnt + 3'd1;
    idx_nx = !sample ? idx : frame_end ? '0 : idx + RW'(1);
  end
  always_comb begin
    row_drv = {ROWS{ROW_IDLE}};
    row_en = '0;
    row_raw = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_drv[r] = idx == RW'(r) ? ~ROW_IDLE : ROW_IDLE;
      for (int c = 0; c < COLS; c++) begin
        row_en[CW'(kp_index(r, c, COLS))] = sample && idx == RW'(r);
        row_raw[CW'(kp_index(r, c, COLS))] = !kp.kp_col[c];
      end
    end
  end
`ifdef KP_GHOST_REJECT_EN
  logic [N-1:0] raw_acc, raw_full;
  logic ghost;
  // Two rows sharing two closed columns form a rectangle: the fourth corner may be phantom.
  always_comb begin
    raw_full = raw_acc | (row_en & row_raw);
    ghost = 1'b0;
    for (int a = 0; a < ROWS; a++)
      for (int b = a + 1; b < ROWS; b++)
        ghost = ghost | ($countones(raw_full[a*COLS +: COLS] & raw_full[b*COLS +: COLS]) > 1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) raw_acc <= '0;
    else raw_acc <= frame_end ? '0 : raw_full;
  assign en = {N{frame_end && !ghost}};
  assign raw = raw_full;
`else
  assign en = row_en;
  assign raw = row_raw;
`endif
  for (genvar k = 0; k < N; k++) begin : g_key
    keypad_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk(clk),
      .rst(rst),
      .en(en[k]),
      .raw(raw[k]),
      .stable(stable[k]),
      .press(press[k]),
      .rel(rel[k]),
      .press_now(press_now[k])
    );
  end
  // Last row's presses are still combinational at frame end, so fold them in before encoding.
  assign acc_full = acc | press_now;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
      frame_done <= 1'b0;
    end else begin
      acc <= frame_end ? '0 : acc_full;
      frame_done <= frame_end;
      key_valid <= frame_end && |acc_full;
      if (frame_end && |acc_full) key_code <= CW'(lsb_index(64'(acc_full)));
    end
  assign kp.kp_row = row_drv;
  assign kp.key_state = stable;
  assign kp.key_press = press;
  assign kp.key_rel = rel;
  assign kp.key_valid = key_valid;
  assign kp.key_code = key_code;
  assign kp.frame_done = frame_done;
endmodule
